// File: rtl/fic_apb_pkg.sv
// fic_apb_pkg: shared types and constants for the FIC_0 APB slot multiplexer
package fic_apb_pkg;
  typedef enum logic [1:0] {IDLE, SSETUP, SACCESS, RESP} state_t;
  localparam int APB_DW = 32;
  localparam logic [APB_DW-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles and flags the last one allowed before abort
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = TIMEOUT_CYCLES != 0 && cnt == LAST;
endmodule

// File: rtl/fic_apb_slot_mux.sv
// fic_apb_slot_mux: decodes the FIC_0 APB window onto NUM_SLOTS re-timed fabric slaves
module fic_apb_slot_mux
  import fic_apb_pkg::*;
#(
  parameter int                NUM_SLOTS      = 4,
  parameter int                SLOT_AW        = 12,
  parameter logic [31:0]       BASE_ADDR      = 32'h5000_0000,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter logic [APB_DW-1:0] ERR_RDATA      = ERR_RDATA_DEF,
  localparam int               IDX_W          = idx_w(NUM_SLOTS)
) (
  input  logic                        FIC_0_CLK,
  input  logic                        FAB_RESET_N,
  input  logic [31:0]                 PADDR,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [APB_DW-1:0]           PWDATA,
  output logic [APB_DW-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [NUM_SLOTS-1:0]        S_PSEL,
  output logic [SLOT_AW-1:0]          S_PADDR,
  output logic                        S_PENABLE,
  output logic                        S_PWRITE,
  output logic [APB_DW-1:0]           S_PWDATA,
  input  logic [APB_DW*NUM_SLOTS-1:0] S_PRDATA,
  input  logic [NUM_SLOTS-1:0]        S_PREADY,
  input  logic [NUM_SLOTS-1:0]        S_PSLVERR,
  input  logic                        CLR_STATUS,
  output logic                        TIMEOUT_IRQ,
  output logic [IDX_W-1:0]            ERR_SLOT
);
  localparam int HI = SLOT_AW + IDX_W;
  state_t state, next;
  logic [IDX_W-1:0] slot, dec_slot;
  logic [APB_DW-1:0] rdata_q;
  logic hit, setup, rdy, expired, timeout, err_q;
  assign dec_slot = PADDR[SLOT_AW +: IDX_W];
  assign hit      = PADDR[31:HI] == BASE_ADDR[31:HI] && 32'(dec_slot) < NUM_SLOTS;
  assign setup    = PSEL & ~PENABLE;
  assign rdy      = S_PREADY[slot];
  assign timeout  = state == SACCESS && !rdy && expired;
  always_comb begin
    next = state == IDLE    ? (setup ? (hit ? SSETUP : RESP) : IDLE)
         : state == SSETUP  ? SACCESS
         : state == SACCESS ? (rdy || expired ? RESP : SACCESS)
         : IDLE;
  end
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N)
    if (!FAB_RESET_N) state <= IDLE;
    else state <= next;
  // rdata defaults to ERR_RDATA at setup so misses and timeouts need no extra load
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N)
    if (!FAB_RESET_N) begin
      slot        <= '0;
      S_PADDR     <= '0;
      S_PWDATA    <= '0;
      S_PWRITE    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      TIMEOUT_IRQ <= 1'b0;
      ERR_SLOT    <= '0;
    end else begin
      if (state == IDLE && setup) begin
        slot     <= dec_slot;
        S_PADDR  <= PADDR[SLOT_AW-1:0];
        S_PWDATA <= PWDATA;
        S_PWRITE <= PWRITE;
        rdata_q  <= ERR_RDATA;
        err_q    <= ~hit;
      end
      if (state == SACCESS && rdy) begin
        rdata_q <= S_PWRITE ? '0 : S_PRDATA[APB_DW*slot +: APB_DW];
        err_q   <= S_PSLVERR[slot];
      end else if (timeout) begin
        rdata_q <= ERR_RDATA;
        err_q   <= 1'b1;
      end
      TIMEOUT_IRQ <= timeout | (TIMEOUT_IRQ & ~CLR_STATUS);
      if (timeout) ERR_SLOT <= slot;
    end
  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clk(FIC_0_CLK), .rst_n(FAB_RESET_N),
    .load(state == SSETUP), .en(state == SACCESS), .expired(expired)
  );
  assign S_PSEL    = state == SSETUP || state == SACCESS ? NUM_SLOTS'(1) << slot : '0;
  assign S_PENABLE = state == SACCESS;
  assign PREADY    = state == RESP;
  assign PRDATA    = PREADY ? rdata_q : '0;
  assign PSLVERR   = PREADY & err_q;
endmodule
